// File: rtl/piso_serializer_pkg.sv
// Serial link package: state encoding and default word/gap sizes.
// Shared by the serializer and the serial-in shift-register receivers.
package piso_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP
    } state_e;

    localparam int unsigned SL_WIDTH = 32'd4;
    localparam int unsigned SL_GAP   = 32'd0;

    // Gap counter start value; only meaningful when gap is non-zero.
    function automatic logic [3:0] gap_load(input int unsigned gap);
        logic [3:0] val;
        if (gap > 32'd0) begin
            val = 4'(gap - 32'd1);
        end else begin
            val = 4'd0;
        end
        return val;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word in, MSB-first bit stream
// out with registered q/q_valid/q_last and an optional forced idle gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SL_WIDTH,
    parameter int unsigned GAP   = SL_GAP
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             q_last_q, q_last_d;
    logic             last_bit_s;
    logic             ready_s;
    logic             accept_s;

    // Ready depends only on registered state, never on din_valid.
    assign last_bit_s = (state_q == S_SHIFT) && (cnt_q == CNT_ZERO);
    assign ready_s    = (state_q == S_IDLE) || ((GAP == 32'd0) && last_bit_s);
    assign accept_s   = din_valid && ready_s;

    // Next-state, counter, shift-register and output-bit logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        sh_d      = sh_q;
        q_d       = 1'b0;
        q_valid_d = 1'b0;
        q_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_q != CNT_ZERO) begin
                    q_d       = sh_q[WIDTH-1];
                    sh_d      = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d     = cnt_q - CNT_ONE;
                    q_valid_d = 1'b1;
                    q_last_d  = (cnt_q == CNT_ONE);
                end else if (GAP > 32'd0) begin
                    state_d = S_GAP;
                    gap_d   = gap_load(GAP);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                gap_d   = 4'd0;
                sh_d    = {WIDTH{1'b0}};
            end
        endcase
        // An accepted word overrides the above: MSB goes straight to q.
        if (accept_s) begin
            state_d   = S_SHIFT;
            cnt_d     = CNT_LOAD;
            sh_d      = {din[WIDTH-2:0], 1'b0};
            q_d       = din[WIDTH-1];
            q_valid_d = 1'b1;
            q_last_d  = 1'b0;
        end else begin
            q_last_d  = q_last_d;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Shift register and registered serial outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q      <= {WIDTH{1'b0}};
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
        end
    end

    assign din_ready = ready_s;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign q_last    = q_last_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: GAP=0 and GAP=3 instances against a cycle-schedule
// model of the serial stream, plus a left-shift receiver fed from the GAP=0 link.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] din0, din3;
    logic       v0, v3;
    logic       r0, q0, qv0, ql0, b0;
    logic       r3, q3, qv3, ql3, b3;
    logic [3:0] rx;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .GAP(0)) dut0 (
        .clk(clk), .rstn(rstn), .din(din0), .din_valid(v0), .din_ready(r0),
        .q(q0), .q_valid(qv0), .q_last(ql0), .busy(b0)
    );

    piso_serializer #(.WIDTH(4), .GAP(3)) dut3 (
        .clk(clk), .rstn(rstn), .din(din3), .din_valid(v3), .din_ready(r3),
        .q(q3), .q_valid(qv3), .q_last(ql3), .busy(b3)
    );

    // Serial-in left-shift receiver on the GAP=0 link.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) rx <= 4'd0;
        else if (qv0) rx <= {rx[2:0], q0};
    end

    int tests = 0;
    int fails = 0;
    int cyc;
    int next_ready;
    int run, max_run;
    bit e_bit[1024], e_v[1024], e_l[1024], e_b[1024], e_rc[1024];
    logic [3:0] e_rw[1024];
    bit o_v[1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) begin
            e_bit[i] = 1'b0; e_v[i] = 1'b0; e_l[i] = 1'b0;
            e_b[i] = 1'b0; e_rc[i] = 1'b0; e_rw[i] = 4'd0; o_v[i] = 1'b0;
        end
        cyc = 0; next_ready = 0; run = 0; max_run = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        v0 = 1'b0; v3 = 1'b0; rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out0", 32'({q0, qv0, ql0, b0}), 32'd0);
        chk("rst_out3", 32'({q3, qv3, ql3, b3}), 32'd0);
        rstn = 1'b1;
        clear_model();
    endtask

    // One cycle: drive inputs, compare outputs with the schedule, book any accept.
    task automatic step(input int sel, input logic v, input logic [3:0] d);
        int gap;
        logic rdy, qq, qv, ql, bz, exp_rdy;
        if (sel == 0) begin
            din0 = d; v0 = v; v3 = 1'b0; gap = 0;
            {rdy, qq, qv, ql, bz} = {r0, q0, qv0, ql0, b0};
        end else begin
            din3 = d; v3 = v; v0 = 1'b0; gap = 3;
            {rdy, qq, qv, ql, bz} = {r3, q3, qv3, ql3, b3};
        end
        exp_rdy = (cyc >= next_ready);
        chk("din_ready", 32'(rdy), 32'(exp_rdy));
        chk("q",         32'(qq),  32'(e_bit[cyc]));
        chk("q_valid",   32'(qv),  32'(e_v[cyc]));
        chk("q_last",    32'(ql),  32'(e_l[cyc]));
        chk("busy",      32'(bz),  32'(e_b[cyc]));
        if (sel == 0 && e_rc[cyc]) chk("rx_word", 32'(rx), 32'(e_rw[cyc]));
        o_v[cyc] = qv;
        run = qv ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (v && exp_rdy) begin
            for (int k = 0; k < 4; k++) begin
                e_bit[cyc + 1 + k] = d[3 - k];
                e_v[cyc + 1 + k]   = 1'b1;
            end
            e_l[cyc + 4] = 1'b1;
            for (int j = 1; j <= 4 + gap; j++) e_b[cyc + j] = 1'b1;
            next_ready = cyc + 4 + ((gap == 0) ? 0 : gap + 1);
            if (sel == 0) begin
                e_rc[cyc + 5] = 1'b1;
                e_rw[cyc + 5] = d;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int accepted;
        int lows;
        logic rv;
        logic [3:0] rd;
        rstn = 1'b0; v0 = 1'b0; v3 = 1'b0; din0 = 4'd0; din3 = 4'd0;

        // Reset then a single word.
        do_reset();
        step(0, 1'b1, 4'b1011);
        repeat (5) step(0, 1'b0, 4'd0);
        chk("single_rx", 32'(rx), 32'(4'b1011));
        chk("single_ready", 32'(r0), 32'd1);

        // Back-to-back words with din_valid held high.
        do_reset();
        step(0, 1'b1, 4'hA);
        repeat (4) step(0, 1'b1, 4'h5);
        repeat (5) step(0, 1'b0, 4'd0);
        chk("b2b_run", 32'(max_run), 32'd8);
        chk("b2b_rx", 32'(rx), 32'(4'h5));

        // Input isolation: din changes during SHIFT.
        do_reset();
        step(0, 1'b1, 4'h9);
        repeat (4) step(0, 1'b1, 4'h6);
        repeat (5) step(0, 1'b0, 4'd0);
        chk("iso_rx", 32'(rx), 32'(4'h6));

        // Forced gap of 3 cycles.
        do_reset();
        step(1, 1'b1, 4'hF);
        repeat (8) step(1, 1'b1, 4'h0);
        repeat (6) step(1, 1'b0, 4'd0);
        lows = 0;
        for (int i = 1; i <= 12; i++) if (!o_v[i]) lows++;
        chk("gap_low_cycles", 32'(lows), 32'd4);

        // Asynchronous reset in the middle of a word.
        do_reset();
        step(0, 1'b1, 4'hC);
        step(0, 1'b0, 4'd0);
        step(0, 1'b0, 4'd0);
        #2 rstn = 1'b0;
        #1 chk("midrst_out", 32'({q0, qv0, ql0, b0}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        clear_model();
        step(0, 1'b1, 4'h3);
        repeat (5) step(0, 1'b0, 4'd0);
        chk("midrst_rx", 32'(rx), 32'(4'h3));

        // Random words into the GAP=0 link and receiver.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 400 && accepted < 20; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rd = 4'($urandom);
            if (rv && cyc >= next_ready) accepted++;
            step(0, rv, rd);
        end
        repeat (6) step(0, 1'b0, 4'd0);
        chk("rand_words", 32'(accepted), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
